// File: rtl/dmem_arbiter_if.sv
// Core, debug/loader and data-memory signals seen by the data-memory arbiter.
// The arbiter takes the slave view; the surrounding core/loader/memory take the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_rvalid;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rdata, dbg_rvalid,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rdata, dbg_rvalid,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of a 1-cycle-read data memory between core and debug port.
// Writes take 1 cycle, reads 2; a losing or read-waiting core is held via cpu_stall, debug via dbg_gnt.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {
        ARB         = 2'd0,
        CPU_RD_WAIT = 2'd1,
        DBG_RD_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    state_e state_q, state_d;
    owner_e last_q, last_d;
    logic   cpu_win;
    logic   dbg_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
            last_q  <= OWN_DBG;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Core wins when alone or when debug owned the previous issue.
    assign cpu_win = bus.cpu_req && (!bus.dbg_req || (last_q == OWN_DBG));
    assign dbg_win = bus.dbg_req && !cpu_win;

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = bus.cpu_addr;
        bus.mem_wdata  = bus.cpu_wdata;
        bus.cpu_stall  = 1'b0;
        bus.dbg_gnt    = 1'b0;
        bus.dbg_rvalid = 1'b0;
        bus.cpu_rdata  = bus.mem_rdata;
        bus.dbg_rdata  = bus.mem_rdata;

        if (!reset) begin
            unique case (state_q)
                ARB: begin
                    if (cpu_win) begin
                        last_d        = OWN_CPU;
                        bus.mem_we    = bus.cpu_we;
                        bus.cpu_stall = !bus.cpu_we;
                        if (!bus.cpu_we) begin
                            state_d = CPU_RD_WAIT;
                        end
                    end else if (dbg_win) begin
                        last_d        = OWN_DBG;
                        bus.dbg_gnt   = 1'b1;
                        bus.mem_we    = bus.dbg_we;
                        bus.mem_addr  = bus.dbg_addr;
                        bus.mem_wdata = bus.dbg_wdata;
                        bus.cpu_stall = bus.cpu_req;
                        if (!bus.dbg_we) begin
                            state_d = DBG_RD_WAIT;
                        end
                    end
                end
                CPU_RD_WAIT: begin
                    state_d = ARB;
                end
                DBG_RD_WAIT: begin
                    bus.dbg_rvalid = 1'b1;
                    bus.cpu_stall  = bus.cpu_req;
                    state_d        = ARB;
                end
                default: begin
                    state_d = ARB;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small 1-cycle-read memory model behind it.
module tb_dmem_arbiter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_set(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    endtask

    task automatic dbg_set(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // Reset with both sides requesting: all control outputs quiet.
        reset = 1'b1;
        cpu_set(1'b1, 1'b1, 32'h10, 32'h1111_1111);
        dbg_set(1'b1, 1'b1, 32'h20, 32'h2222_2222);
        step(); step();
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("rst_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
        chk("rst_rvalid", {31'd0, bus.dbg_rvalid}, 32'd0);
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
        dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        step();

        // Idle: no write, address from the cpu port.
        cpu_set(1'b0, 1'b0, 32'h44, 32'h0);
        #1;
        chk("idle_we", {31'd0, bus.mem_we}, 32'd0);
        chk("idle_addr", bus.mem_addr, 32'h44);
        step();

        // Uncontended CPU write then read.
        cpu_set(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        #1;
        chk("cw_we", {31'd0, bus.mem_we}, 32'd1);
        chk("cw_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("cw_addr", bus.mem_addr, 32'h10);
        chk("cw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        step();
        cpu_set(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        chk("cr_stall", {31'd0, bus.cpu_stall}, 32'd1);
        chk("cr_we", {31'd0, bus.mem_we}, 32'd0);
        step();
        chk("cr_wait_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("cr_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
        chk("cr_wait_we", {31'd0, bus.mem_we}, 32'd0);
        step();
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0);

        // Debug write then read.
        dbg_set(1'b1, 1'b1, 32'h20, 32'h1234_5678);
        #1;
        chk("dw_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
        chk("dw_we", {31'd0, bus.mem_we}, 32'd1);
        chk("dw_addr", bus.mem_addr, 32'h20);
        chk("dw_wdata", bus.mem_wdata, 32'h1234_5678);
        step();
        dbg_set(1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        chk("dr_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
        chk("dr_we", {31'd0, bus.mem_we}, 32'd0);
        step();
        dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("dr_rvalid", {31'd0, bus.dbg_rvalid}, 32'd1);
        chk("dr_rdata", bus.dbg_rdata, 32'h1234_5678);
        chk("dr_wait_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
        step();
        chk("dr_rvalid_pulse", {31'd0, bus.dbg_rvalid}, 32'd0);

        // Preload 0x0/0x4, reset, then first contention of two reads.
        dbg_set(1'b1, 1'b1, 32'h0, 32'hA0A0_A0A0);
        step();
        dbg_set(1'b1, 1'b1, 32'h4, 32'hB4B4_B4B4);
        step();
        dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cpu_set(1'b1, 1'b0, 32'h0, 32'h0);
        dbg_set(1'b1, 1'b0, 32'h4, 32'h0);
        #1;
        chk("ct_cpu_first_stall", {31'd0, bus.cpu_stall}, 32'd1);
        chk("ct_cpu_first_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
        chk("ct_cpu_first_addr", bus.mem_addr, 32'h0);
        step();
        chk("ct_cpu_rdata", bus.cpu_rdata, 32'hA0A0_A0A0);
        chk("ct_cpu_wait_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("ct_cpu_wait_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
        step();
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("ct_dbg_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
        chk("ct_dbg_addr", bus.mem_addr, 32'h4);
        step();
        dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("ct_dbg_rvalid", {31'd0, bus.dbg_rvalid}, 32'd1);
        chk("ct_dbg_rdata", bus.dbg_rdata, 32'hB4B4_B4B4);
        chk("ct_dbg_wait_stall", {31'd0, bus.cpu_stall}, 32'd0);
        step();

        // Continuous contending writes: debug owned last, so CPU starts.
        begin
            int cpu_n;
            int dbg_n;
            cpu_n = 0;
            dbg_n = 0;
            for (int i = 0; i < 8; i++) begin
                cpu_set(1'b1, 1'b1, 32'h40 + cpu_n, 32'hC000_0000 + cpu_n);
                dbg_set(1'b1, 1'b1, 32'h80 + dbg_n, 32'hD000_0000 + dbg_n);
                #1;
                chk($sformatf("alt%0d_gnt", i), {31'd0, bus.dbg_gnt}, i % 2);
                chk($sformatf("alt%0d_stall", i), {31'd0, bus.cpu_stall}, i % 2);
                chk($sformatf("alt%0d_we", i), {31'd0, bus.mem_we}, 32'd1);
                chk($sformatf("alt%0d_addr", i), bus.mem_addr,
                    (i % 2 == 0) ? 32'h40 + i / 2 : 32'h80 + i / 2);
                if (bus.dbg_gnt) dbg_n++;
                if (!bus.cpu_stall) cpu_n++;
                step();
            end
            chk("alt_cpu_count", cpu_n, 32'd4);
            chk("alt_dbg_count", dbg_n, 32'd4);
        end
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
        dbg_set(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset during DBG_RD_WAIT discards the read.
        dbg_set(1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        chk("rw_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
        step();
        dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        chk("rw_rvalid_in_rst", {31'd0, bus.dbg_rvalid}, 32'd0);
        step();
        reset = 1'b0;
        cpu_set(1'b1, 1'b1, 32'h50, 32'h5555_5555);
        dbg_set(1'b1, 1'b1, 32'h54, 32'h6666_6666);
        #1;
        chk("rw_no_rvalid", {31'd0, bus.dbg_rvalid}, 32'd0);
        chk("rw_cpu_first_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("rw_cpu_first_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
        chk("rw_cpu_first_addr", bus.mem_addr, 32'h50);
        step();
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rw_dbg_next_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
        step();
        dbg_set(1'b0, 1'b0, 32'h0, 32'h0);

        // Debug read with idle CPU; CPU write arrives during DBG_RD_WAIT.
        dbg_set(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        chk("dc_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
        chk("dc_idle_stall", {31'd0, bus.cpu_stall}, 32'd0);
        step();
        dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        cpu_set(1'b1, 1'b1, 32'h30, 32'h3030_3030);
        #1;
        chk("dc_wait_stall", {31'd0, bus.cpu_stall}, 32'd1);
        chk("dc_wait_we", {31'd0, bus.mem_we}, 32'd0);
        chk("dc_rvalid", {31'd0, bus.dbg_rvalid}, 32'd1);
        chk("dc_rdata", bus.dbg_rdata, 32'hDEAD_BEEF);
        step();
        chk("dc_cw_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("dc_cw_we", {31'd0, bus.mem_we}, 32'd1);
        chk("dc_cw_addr", bus.mem_addr, 32'h30);
        step();
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0);

        // Read back alternation data and the late CPU write through the core port.
        cpu_set(1'b1, 1'b0, 32'h83, 32'h0);
        step();
        chk("rb_dbg_alt", bus.cpu_rdata, 32'hD000_0003);
        step();
        cpu_set(1'b1, 1'b0, 32'h30, 32'h0);
        step();
        chk("rb_cpu_late", bus.cpu_rdata, 32'h3030_3030);
        step();
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
